shift_register_seq: RTL and testbench
=====================================

SHIFT_REGISTER_SEQ -- requirements
Module: shift_register_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits; legal range 2..64.
REQ-002 The block SHALL have localparam AMT_W, default $clog2(WIDTH), meaning width of the shift-amount field.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-007 The block SHALL have port cmd_op, input, 3 bits: operation code.
REQ-008 The block SHALL have port cmd_amt, input, AMT_W bits: shift/rotate step count.
REQ-009 The block SHALL have port cmd_data, input, WIDTH bits: parallel load value.
REQ-010 The block SHALL have port ser_in, input, 1 bit: serial fill bit for logical shifts.
REQ-011 The block SHALL have port op, output, WIDTH bits: register contents.
REQ-012 The block SHALL have port ser_out, output, 1 bit: bit expelled or wrapped by the most recent step.
REQ-013 The block SHALL have port busy, output, 1 bit: multi-step operation in progress.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 Opcodes SHALL be: 000 LOAD (op=cmd_data), 001 SHL (toward MSB, LSB filled with ser_in), 010 SHR (toward LSB, MSB filled with ser_in), 011 ROL (MSB to LSB), 100 ROR (LSB to MSB), 101 ASR (toward LSB, MSB preserved), 110 CLR (op=0), 111 NOP.
REQ-016 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL equal !busy.
REQ-017 The FSM SHALL have two states, IDLE (busy=0) and SHIFT (busy=1).
REQ-018 LOAD, CLR and NOP SHALL update op on the accept edge, stay in IDLE and raise done for the following cycle.
REQ-019 A shift or rotate with cmd_amt=0 SHALL leave op and ser_out unchanged and behave as NOP.
REQ-020 A shift or rotate with cmd_amt=k>0 SHALL perform step 1 on the accept edge; if k>1 it SHALL enter SHIFT and perform one step per edge until k steps are done, then return to IDLE.
REQ-021 For k>1, busy SHALL be high for exactly k-1 cycles.
REQ-022 done SHALL be high for exactly one cycle, the cycle immediately after the edge performing the final step.
REQ-023 ser_in SHALL be sampled on every step edge (live value, not latched at accept).
REQ-024 Opcode and remaining count SHALL be latched at accept; cmd_* changes during SHIFT SHALL have no effect.
REQ-025 On each step, ser_out SHALL be set to the departing bit: old op[WIDTH-1] for SHL and ROL, old op[0] for SHR, ASR and ROR.
REQ-026 LOAD and NOP SHALL leave ser_out unchanged; CLR SHALL clear ser_out to 0.
REQ-027 A command offered in the cycle done is high SHALL be accepted, so back-to-back commands are legal.
REQ-028 cmd_valid while busy SHALL be ignored and not queued.

Reset
REQ-029 While rst_n=0 the block SHALL asynchronously force op=0, ser_out=0, busy=0, done=0, state IDLE and count 0; cmd_ready SHALL then read 1.
REQ-030 Reset asserted mid-operation SHALL abort the operation, with no done pulse issued.

Verification (WIDTH=8)
REQ-031 Assert rst_n=0 mid-cycle -> op=0x00, ser_out=0, busy=0, done=0 and cmd_ready=1 without waiting for a clock edge.
REQ-032 LOAD 0xA5 -> op=0xA5 after the accept edge, done high one cycle, busy never high.
REQ-033 LOAD 0x81 then ROL k=3 -> op 0x03, 0x06, 0x0C on successive edges; busy high 2 cycles; ser_out 1, 0, 0; single done pulse.
REQ-034 LOAD 0x90 then ASR k=2 -> op 0xC8 then 0xE4; ser_out 0 then 0; done once.
REQ-035 CLR, then SHL k=7 with ser_in=1 -> op=0x7F after 7 steps; a LOAD 0xFF held on cmd_valid during busy is ignored, then accepted on the done cycle -> op=0xFF.
REQ-036 SHR k=5 from 0xFF, rst_n pulsed low after step 2 -> op=0x00 immediately, busy=0, no done pulse, next command accepted normally.

Source files
------------

// File: rtl/shift_register_seq.sv
// Command-driven shift/rotate register: single-cycle LOAD/CLR/NOP, multi-step
// shifts and rotates executed one step per clock with busy/done handshaking.
module shift_register_seq #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] op,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ASR  = 3'b101,
        OP_CLR  = 3'b110,
        OP_NOP  = 3'b111
    } opcode_t;

    state_t             state, state_nx;
    opcode_t            code, code_nx;
    logic [AMT_W-1:0]   count, count_nx;
    logic [WIDTH-1:0]   op_nx;
    logic               ser_nx;
    logic               done_nx;
    logic [WIDTH:0]     step_res;

    // Returns {departing bit, stepped value}.
    function automatic logic [WIDTH:0] step_fn(input opcode_t c,
                                               input logic [WIDTH-1:0] v,
                                               input logic fill);
        case (c)
            OP_SHL:  step_fn = {v[WIDTH-1], v[WIDTH-2:0], fill};
            OP_SHR:  step_fn = {v[0], fill, v[WIDTH-1:1]};
            OP_ROL:  step_fn = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  step_fn = {v[0], v[0], v[WIDTH-1:1]};
            OP_ASR:  step_fn = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: step_fn = {1'b0, v};
        endcase
    endfunction

    assign busy      = (state == SHIFT);
    assign cmd_ready = !busy;

    always_comb begin
        state_nx = state;
        code_nx  = code;
        count_nx = count;
        op_nx    = op;
        ser_nx   = ser_out;
        done_nx  = 1'b0;
        step_res = step_fn((state == SHIFT) ? code : opcode_t'(cmd_op), op, ser_in);
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    done_nx = 1'b1;
                    case (opcode_t'(cmd_op))
                        OP_LOAD: op_nx = cmd_data;
                        OP_CLR: begin
                            op_nx  = '0;
                            ser_nx = 1'b0;
                        end
                        OP_NOP: ;
                        default: begin
                            // amt=0 falls through as a NOP; first step happens on the accept edge
                            if (cmd_amt != '0) begin
                                op_nx  = step_res[WIDTH-1:0];
                                ser_nx = step_res[WIDTH];
                                if (cmd_amt != AMT_W'(1)) begin
                                    done_nx  = 1'b0;
                                    state_nx = SHIFT;
                                    count_nx = cmd_amt - AMT_W'(1);
                                    code_nx  = opcode_t'(cmd_op);
                                end
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                op_nx    = step_res[WIDTH-1:0];
                ser_nx   = step_res[WIDTH];
                count_nx = count - AMT_W'(1);
                if (count == AMT_W'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= OP_NOP;
            count   <= '0;
            op      <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            code    <= code_nx;
            count   <= count_nx;
            op      <= op_nx;
            ser_out <= ser_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed bench for shift_register_seq (WIDTH=8): per-cycle expectations are
// queued as stimulus is driven and checked after each rising edge.
module tb_shift_register_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             ser_in;
    logic [WIDTH-1:0] op;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] op;
        logic             ser;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb[$];

    shift_register_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .ser_in(ser_in),
        .op(op), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_now(input exp_t e);
        n_assert++;
        assert (op === e.op) else begin
            n_fail++;
            $error("FAIL %s op: got %h expected %h", e.tag, op, e.op);
        end
        n_assert++;
        assert (ser_out === e.ser) else begin
            n_fail++;
            $error("FAIL %s ser_out: got %b expected %b", e.tag, ser_out, e.ser);
        end
        n_assert++;
        assert (busy === e.busy) else begin
            n_fail++;
            $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
        end
        n_assert++;
        assert (done === e.done) else begin
            n_fail++;
            $error("FAIL %s done: got %b expected %b", e.tag, done, e.done);
        end
        n_assert++;
        assert (cmd_ready === !e.busy) else begin
            n_fail++;
            $error("FAIL %s cmd_ready: got %b expected %b", e.tag, cmd_ready, !e.busy);
        end
    endtask

    // Queue expectation for the cycle following the next rising edge, then check it.
    task automatic cycle(input string tag, input logic [WIDTH-1:0] e_op,
                         input logic e_ser, input logic e_busy, input logic e_done);
        exp_t e;
        e.tag = tag; e.op = e_op; e.ser = e_ser; e.busy = e_busy; e.done = e_done;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_now(sb.pop_front());
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [AMT_W-1:0] a,
                         input logic [WIDTH-1:0] d);
        cmd_valid = v; cmd_op = c; cmd_amt = a; cmd_data = d;
    endtask

    initial begin
        exp_t r;
        rst_n = 1'b0;
        ser_in = 1'b0;
        drive(1'b0, 3'b111, '0, '0);
        #3;
        r.tag = "reset_init"; r.op = 8'h00; r.ser = 1'b0; r.busy = 1'b0; r.done = 1'b0;
        check_now(r);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 3'b000, 3'd0, 8'hA5);
        cycle("load_a5", 8'hA5, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 3'd0, 8'h00);
        cycle("load_a5_idle", 8'hA5, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 3'b000, 3'd0, 8'h81);
        cycle("load_81", 8'h81, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b011, 3'd3, 8'h00);
        cycle("rol_s1", 8'h03, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 3'b011, 3'd3, 8'h00);
        cycle("rol_s2", 8'h06, 1'b0, 1'b1, 1'b0);
        cycle("rol_s3", 8'h0C, 1'b0, 1'b0, 1'b1);
        cycle("rol_idle", 8'h0C, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 3'b000, 3'd0, 8'h90);
        cycle("load_90", 8'h90, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b101, 3'd2, 8'h00);
        cycle("asr_s1", 8'hC8, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'b101, 3'd2, 8'h00);
        cycle("asr_s2", 8'hE4, 1'b0, 1'b0, 1'b1);
        cycle("asr_idle", 8'hE4, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 3'b110, 3'd0, 8'h00);
        cycle("clr", 8'h00, 1'b0, 1'b0, 1'b1);
        ser_in = 1'b1;
        drive(1'b1, 3'b001, 3'd7, 8'h00);
        cycle("shl_s1", 8'h01, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b000, 3'd0, 8'hFF);
        cycle("shl_s2", 8'h03, 1'b0, 1'b1, 1'b0);
        cycle("shl_s3", 8'h07, 1'b0, 1'b1, 1'b0);
        cycle("shl_s4", 8'h0F, 1'b0, 1'b1, 1'b0);
        cycle("shl_s5", 8'h1F, 1'b0, 1'b1, 1'b0);
        cycle("shl_s6", 8'h3F, 1'b0, 1'b1, 1'b0);
        cycle("shl_s7", 8'h7F, 1'b0, 1'b0, 1'b1);
        cycle("load_ff_b2b", 8'hFF, 1'b0, 1'b0, 1'b1);

        ser_in = 1'b0;
        drive(1'b1, 3'b100, 3'd0, 8'h00);
        cycle("ror_k0", 8'hFF, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b000, 3'd0, 8'h05);
        cycle("load_05", 8'h05, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b100, 3'd2, 8'h00);
        cycle("ror2_s1", 8'h82, 1'b1, 1'b1, 1'b0);
        cycle("ror2_s2", 8'h41, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b100, 3'd1, 8'h00);
        cycle("ror1", 8'hA0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'b000, 3'd0, 8'h12);
        cycle("load_keeps_ser", 8'h12, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'b111, 3'd5, 8'h77);
        cycle("nop", 8'h12, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'b110, 3'd0, 8'h00);
        cycle("clr_ser", 8'h00, 1'b0, 1'b0, 1'b1);

        drive(1'b1, 3'b000, 3'd0, 8'h01);
        cycle("load_01", 8'h01, 1'b0, 1'b0, 1'b1);
        ser_in = 1'b1;
        drive(1'b1, 3'b010, 3'd3, 8'h00);
        cycle("shr_live_s1", 8'h80, 1'b1, 1'b1, 1'b0);
        ser_in = 1'b0;
        drive(1'b0, 3'b110, 3'd0, 8'h00);
        cycle("shr_live_s2", 8'h40, 1'b0, 1'b1, 1'b0);
        ser_in = 1'b1;
        cycle("shr_live_s3", 8'hA0, 1'b0, 1'b0, 1'b1);
        cycle("shr_live_idle", 8'hA0, 1'b0, 1'b0, 1'b0);

        ser_in = 1'b0;
        drive(1'b1, 3'b000, 3'd0, 8'hFF);
        cycle("load_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'b010, 3'd5, 8'h00);
        cycle("shr5_s1", 8'h7F, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 3'b010, 3'd5, 8'h00);
        cycle("shr5_s2", 8'h3F, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        r.tag = "reset_mid"; r.op = 8'h00; r.ser = 1'b0; r.busy = 1'b0; r.done = 1'b0;
        check_now(r);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        cycle("post_reset_nodone", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 3'd0, 8'h3C);
        cycle("post_reset_load", 8'h3C, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 3'd0, 8'h00);
        cycle("final_idle", 8'h3C, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
